branch_trace_encoder: RTL and testbench

//   Encodes the retired control-flow stream into compact byte packets for an off-chip trace probe.

---
 rtl/branch_trace_encoder.sv | 172 +++++++++++++++++
 tb/tb_branch_trace_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_trace_encoder.sv
// Retire-stream trace encoder: packs branch/sequential events into byte packets,
// buffers them in a packet FIFO and serialises them onto a valid/ready byte stream.

package decoder_pkg;
    typedef enum logic {
        PC_NEXT   = 1'b0,
        PC_BRANCH = 1'b1
    } pc_mux_t;
endpackage

package branch_trace_encoder_pkg;
    typedef struct packed {
        logic        is_br;
        logic [6:0]  count;
        logic [31:0] target;
    } trace_pkt_t;
endpackage

module branch_trace_encoder
    import decoder_pkg::*;
    import branch_trace_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            retire_valid,
    input  pc_mux_t                         retire_pc_sel,
    input  logic [31:0]                     retire_target,
    input  logic                            flush,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_B0,
        S_B1,
        S_B2,
        S_B3
    } state_t;

    state_t             state_q, state_d;
    trace_pkt_t         shadow_q, shadow_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    trace_pkt_t         mem_q [FIFO_DEPTH];

    logic               push_c;
    trace_pkt_t         push_pkt_c;
    logic               pop_c;
    logic               accept_c;
    logic               full_c;
    logic               empty_c;

    assign full_c   = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty_c  = (level_q == '0);
    assign accept_c = push_c && (!full_c || pop_c);

    // Packet generation; a dropped push still advances seq_cnt
    always_comb begin
        push_c     = 1'b0;
        push_pkt_c = '0;
        seq_cnt_d  = seq_cnt_q;
        if (retire_valid) begin
            if (retire_pc_sel == PC_BRANCH) begin
                push_c     = 1'b1;
                push_pkt_c = '{is_br: 1'b1, count: seq_cnt_q, target: retire_target};
                seq_cnt_d  = '0;
            end else if (seq_cnt_q == CNT_W'(127)) begin
                push_c     = 1'b1;
                push_pkt_c = '{is_br: 1'b0, count: seq_cnt_q, target: 32'h0};
                seq_cnt_d  = CNT_W'(1);
            end else begin
                seq_cnt_d  = seq_cnt_q + CNT_W'(1);
            end
        end else if (flush && (seq_cnt_q != '0)) begin
            push_c     = 1'b1;
            push_pkt_c = '{is_br: 1'b0, count: seq_cnt_q, target: 32'h0};
            seq_cnt_d  = '0;
        end
    end

    always_comb begin
        overflow_d = overflow_q | (push_c & ~accept_c);
        level_d    = level_q;
        case ({accept_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Serialiser next state; tx outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        pop_c      = 1'b0;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    pop_c    = 1'b1;
                    shadow_d = mem_q[rd_ptr_q];
                    state_d  = S_HDR;
                end
            end
            S_HDR:   if (tx_ready) state_d = shadow_q.is_br ? S_B0 : S_IDLE;
            S_B0:    if (tx_ready) state_d = S_B1;
            S_B1:    if (tx_ready) state_d = S_B2;
            S_B2:    if (tx_ready) state_d = S_B3;
            S_B3:    if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        case (state_d)
            S_HDR:   tx_data_d = {shadow_d.is_br, shadow_d.count};
            S_B0:    tx_data_d = shadow_d.target[7:0];
            S_B1:    tx_data_d = shadow_d.target[15:8];
            S_B2:    tx_data_d = shadow_d.target[23:16];
            S_B3:    tx_data_d = shadow_d.target[31:24];
            default: tx_data_d = 8'h00;
        endcase
        tx_valid_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            seq_cnt_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            seq_cnt_q  <= seq_cnt_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            if (accept_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) mem_q[wr_ptr_q] <= push_pkt_c;
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_branch_trace_encoder.sv
// Scoreboard bench for branch_trace_encoder: stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted byte and checks stall stability.

module tb_branch_trace_encoder;
    import decoder_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        retire_valid;
    pc_mux_t     retire_pc_sel;
    logic [31:0] retire_target;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [3:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] held_data  = 8'h00;

    branch_trace_encoder #(.FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .retire_valid  (retire_valid),
        .retire_pc_sel (retire_pc_sel),
        .retire_target (retire_target),
        .flush         (flush),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_br(input logic [6:0] cnt, input logic [31:0] tgt);
        exp_q.push_back({1'b1, cnt});
        exp_q.push_back(tgt[7:0]);
        exp_q.push_back(tgt[15:8]);
        exp_q.push_back(tgt[23:16]);
        exp_q.push_back(tgt[31:24]);
    endtask

    task automatic retire_next();
        retire_valid  = 1'b1;
        retire_pc_sel = PC_NEXT;
        step();
        retire_valid  = 1'b0;
    endtask

    task automatic retire_branch(input logic [31:0] tgt);
        retire_valid  = 1'b1;
        retire_pc_sel = PC_BRANCH;
        retire_target = tgt;
        step();
        retire_valid  = 1'b0;
        retire_pc_sel = PC_NEXT;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || fifo_level != 0 || tx_valid) && cyc < 2000) begin
            step();
            cyc++;
        end
        if (cyc >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain timeout: %0d bytes still expected, level %0d", name, exp_q.size(), fifo_level);
            exp_q.delete();
        end
    endtask

    // Monitor: compare accepted bytes in order, and require held outputs while stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_tests++;
                if (!(tx_valid && tx_data == held_data)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                             tx_valid, tx_data, held_data);
                end
            end
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_unexpected: got 0x%0h with no byte expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL byte: got 0x%0h expected 0x%0h", tx_data, e);
                    end
                end
            end
            stall_prev = tx_valid && !tx_ready;
            held_data  = tx_data;
        end
    end

    initial begin
        int cyc;
        reset_n       = 1'b0;
        retire_valid  = 1'b0;
        retire_pc_sel = PC_NEXT;
        retire_target = 32'h0;
        flush         = 1'b0;
        tx_ready      = 1'b1;
        repeat (3) step();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset_n = 1'b1;
        step();

        // 1: three sequential then a branch
        repeat (3) retire_next();
        exp_br(7'd3, 32'h8000_0104);
        retire_branch(32'h8000_0104);
        drain("t1");
        chk("t1_overflow", 32'(overflow), 32'd0);

        // 2: counter saturation at 127 then flush of the remainder
        for (int i = 0; i < 130; i++) begin
            if (i == 127) exp_q.push_back(8'h7F);
            retire_next();
        end
        exp_q.push_back(8'h03);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("t2");

        // 4: FIFO full while the IDLE pop coincides with a push
        tx_ready = 1'b0;
        retire_next();
        exp_q.push_back(8'h01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_br(7'd0, 32'h4000_0000 | 32'(i));
            retire_branch(32'h4000_0000 | 32'(i));
        end
        step();
        chk("t4_level_full", 32'(fifo_level), 32'd8);
        chk("t4_hdr_valid", 32'(tx_valid), 32'd1);
        chk("t4_hdr_data", 32'(tx_data), 32'h01);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("t4_idle_bubble", 32'(tx_valid), 32'd0);
        exp_br(7'd0, 32'h4000_00AA);
        retire_branch(32'h4000_00AA);
        chk("t4_level_kept", 32'(fifo_level), 32'd8);
        chk("t4_overflow", 32'(overflow), 32'd0);
        tx_ready = 1'b1;
        drain("t4");

        // 3: ten branches into a stalled sink
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_br(7'd0, 32'hA0B0_C000 | 32'(i));
            retire_branch(32'hA0B0_C000 | 32'(i));
        end
        step();
        chk("t3_level", 32'(fifo_level), 32'd8);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_shadow_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        drain("t3");
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // 5: reset while B2 of a BR packet is on the bus
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        retire_branch(32'hDEAD_BEEF);
        cyc = 0;
        while (!(tx_valid && tx_data == 8'hBE) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("t5_reach_b1", 32'(cyc < 50), 32'd1);
        step();
        tx_ready = 1'b0;
        chk("t5_b2_data", 32'(tx_data), 32'hAD);
        step();
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(tx_valid), 32'd0);
        chk("t5_rst_data", 32'(tx_data), 32'd0);
        chk("t5_rst_level", 32'(fifo_level), 32'd0);
        chk("t5_rst_overflow", 32'(overflow), 32'd0);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
        step();
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        step();
        retire_next();
        retire_next();
        exp_br(7'd2, 32'h0000_0042);
        retire_branch(32'h0000_0042);
        drain("t5");

        // 6: random backpressure across a BR packet
        tx_ready = 1'b0;
        repeat (5) retire_next();
        exp_br(7'd5, 32'h1234_5678);
        retire_branch(32'h1234_5678);
        for (int i = 0; i < 40; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            step();
        end
        tx_ready = 1'b1;
        drain("t6");
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
